// File: rtl/shift_left_sequencer.sv
// shift_left_sequencer
//   Handshaked controller that drives an 8-lane x 12-bit left lane shifter.
//   A request of 0..8 lanes is split into one or two shifter passes of at
//   most MAX_STEP lanes each; intermediate data lives in a work register and
//   the finished word is offered downstream with a valid/ready handshake.
//
// Optional feature macro: SHIFT_SEQ_ERR_EN
//   Defined   : out_err port exists; in_amt > 8 is accepted and reported as an
//               error result (out_data=0, out_passes=0, out_err=1) after 1 cycle.
//   Undefined : no out_err port; in_amt 9..15 saturates to 8 lanes.
//
// Ports:
//   clk         in   1    clock, rising edge
//   rst         in   1    asynchronous, active-high reset
//   in_valid    in   1    request valid
//   in_ready    out  1    block can accept a request (IDLE only)
//   in_data     in   96   word to shift; lane k = bits [12k+11:12k]
//   in_amt      in   4    shift amount in lanes
//   in_fill     in   12   pattern written into every vacated low lane
//   out_valid   out  1    result valid (DONE only)
//   out_ready   in   1    downstream accepts the result
//   out_data    out  96   shifted word
//   out_passes  out  2    shifter passes used for this result (0..2)
//   out_err     out  1    illegal amount flag (SHIFT_SEQ_ERR_EN only)

// Checker for the per-pass shifter contract: every pass issued in SHIFT must
// be a legal, non-zero step that the shifter flags valid.
module shift_left_sequencer_chk (
  input logic clk,
  input logic rst,
  input logic in_shift,
  input logic pass_valid,
  input logic step_nonzero
);

  a_pass_valid: assert property (@(posedge clk) disable iff (rst)
    in_shift |-> (pass_valid && step_nonzero));

endmodule

module shift_left_sequencer #(
  parameter int LANES    = 8,
  parameter int LANE_W   = 12,
  parameter int MAX_STEP = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic [3:0]              in_amt,
  input  logic [LANE_W-1:0]       in_fill,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic [1:0]              out_passes
`ifdef SHIFT_SEQ_ERR_EN
  ,
  output logic                    out_err
`endif
);

  localparam int WORD_W = LANES * LANE_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Behavioural model of the lane shifter: lane k takes lane k-amt, vacated
  // low lanes take the fill pattern.
  function automatic logic [WORD_W-1:0] f_shift_lanes(
    input logic [WORD_W-1:0] word,
    input logic [3:0]        amt,
    input logic [LANE_W-1:0] fill
  );
    logic [WORD_W-1:0] res;
    res = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k >= int'(amt)) begin
        res[k*LANE_W +: LANE_W] = word[(k - int'(amt))*LANE_W +: LANE_W];
      end else begin
        res[k*LANE_W +: LANE_W] = fill;
      end
    end
    return res;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WORD_W-1:0]   r_work;
  logic [LANE_W-1:0]   r_fill;
  logic [3:0]          r_rem;
  logic [1:0]          r_passes;
  logic                r_err;

  logic [3:0]          w_amt_sat;
  logic                w_err_req;
  logic [3:0]          w_step;
  logic [3:0]          w_rem_nxt;
  logic                w_pass_valid;
  logic [WORD_W-1:0]   w_shift_data;

  // Request decode: saturate the amount and flag illegal amounts.
  always_comb begin
    w_amt_sat = in_amt;
    if (in_amt > 4'd8) begin
      w_amt_sat = 4'd8;
    end else begin
      w_amt_sat = in_amt;
    end
`ifdef SHIFT_SEQ_ERR_EN
    w_err_req = (in_amt > 4'd8);
`else
    w_err_req = 1'b0;
`endif
  end

  // Pass planning: take at most MAX_STEP lanes per pass from the remainder.
  always_comb begin
    w_step = r_rem;
    if (r_rem > 4'(MAX_STEP)) begin
      w_step = 4'(MAX_STEP);
    end else begin
      w_step = r_rem;
    end
    w_rem_nxt    = r_rem - w_step;
    w_pass_valid = (w_step <= 4'(MAX_STEP));
    w_shift_data = f_shift_lanes(r_work, w_step, r_fill);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; an error request or a zero amount skips SHIFT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_err_req || (w_amt_sat == 4'd0)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SHIFT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_rem_nxt == 4'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM outputs: handshake flags decode directly from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: capture the request in IDLE, apply one pass per SHIFT cycle,
  // hold everything in DONE so the outputs stay stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work   <= '0;
      r_fill   <= '0;
      r_rem    <= 4'd0;
      r_passes <= 2'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work   <= w_err_req ? '0 : in_data;
            r_fill   <= in_fill;
            r_rem    <= w_err_req ? 4'd0 : w_amt_sat;
            r_passes <= 2'd0;
            r_err    <= w_err_req;
          end
        end
        S_SHIFT: begin
          r_work   <= w_shift_data;
          r_rem    <= w_rem_nxt;
          r_passes <= r_passes + 2'd1;
        end
        default: begin
          r_work <= r_work;
        end
      endcase
    end
  end

  assign out_data   = r_work;
  assign out_passes = r_passes;
`ifdef SHIFT_SEQ_ERR_EN
  assign out_err    = r_err;
`endif

`ifndef SYNTHESIS
  shift_left_sequencer_chk u_chk (
    .clk          (clk),
    .rst          (rst),
    .in_shift     (r_state == S_SHIFT),
    .pass_valid   (w_pass_valid),
    .step_nonzero (w_step != 4'd0)
  );
`endif

endmodule

// File: tb/tb_shift_left_sequencer.sv
// Self-checking bench for shift_left_sequencer. Expected results come from a
// direct (single-step) lane-shift model and are queued at request time, then
// popped and compared when out_valid rises.
module tb_shift_left_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_data;
  logic [3:0]  in_amt;
  logic [11:0] in_fill;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_data;
  logic [1:0]  out_passes;
  logic        out_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [95:0] data;
    logic [1:0]  passes;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  shift_left_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_fill    (in_fill),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_passes (out_passes)
`ifdef SHIFT_SEQ_ERR_EN
    ,
    .out_err    (out_err)
`endif
  );

  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: shift by the whole (saturated) amount in one go.
  function automatic exp_t model(input logic [95:0] d, input logic [3:0] amt, input logic [11:0] fill);
    exp_t e;
    int   a;
    a = (amt > 4'd8) ? 8 : int'(amt);
    e.err = 1'b0;
    e.data = '0;
    for (int k = 0; k < 8; k++) begin
      if (k >= a) e.data[k*12 +: 12] = d[(k-a)*12 +: 12];
      else        e.data[k*12 +: 12] = fill;
    end
    e.passes = (a == 0) ? 2'd0 : ((a <= 5) ? 2'd1 : 2'd2);
    e.lat    = (a == 0) ? 1 : ((a <= 5) ? 2 : 3);
`ifdef SHIFT_SEQ_ERR_EN
    if (amt > 4'd8) begin
      e.data = '0; e.passes = 2'd0; e.err = 1'b1; e.lat = 1;
    end
`endif
    return e;
  endfunction

  // Issue one request, wait for the result, compare, apply hold cycles of
  // backpressure, then complete the output handshake.
  task automatic do_req(input logic [95:0] d, input logic [3:0] amt, input logic [11:0] fill, input int hold);
    exp_t        e;
    int          lat;
    logic [95:0] snap;
    check_eq("in_ready_before_req", {95'd0, in_ready}, 96'd1);
    in_valid = 1'b1; in_data = d; in_amt = amt; in_fill = fill;
    sb_q.push_back(model(d, amt, fill));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom};
    in_amt   = 4'($urandom_range(0, 15));
    in_fill  = 12'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb_q.pop_front();
    check_eq("latency", 96'(lat), 96'(e.lat));
    check_eq("in_ready_in_done", {95'd0, in_ready}, 96'd0);
    check_eq("out_data", out_data, e.data);
    check_eq("out_passes", {94'd0, out_passes}, {94'd0, e.passes});
`ifdef SHIFT_SEQ_ERR_EN
    check_eq("out_err", {95'd0, out_err}, {95'd0, e.err});
`endif
    snap = out_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("hold_data", out_data, snap);
      check_eq("hold_valid", {95'd0, out_valid}, 96'd1);
      check_eq("hold_in_ready", {95'd0, in_ready}, 96'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("valid_after_hs", {95'd0, out_valid}, 96'd0);
    check_eq("in_ready_after_hs", {95'd0, in_ready}, 96'd1);
  endtask

  initial begin
    logic [95:0] lanes;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = 4'd0; in_fill = 12'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", {95'd0, in_ready}, 96'd1);
    check_eq("rst_out_valid", {95'd0, out_valid}, 96'd0);
    check_eq("rst_out_data", out_data, 96'd0);
    check_eq("rst_out_passes", {94'd0, out_passes}, 96'd0);
`ifdef SHIFT_SEQ_ERR_EN
    check_eq("rst_out_err", {95'd0, out_err}, 96'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) lanes[k*12 +: 12] = 12'h100 + 12'(k);

    do_req(96'h0123456789ABCDEF01234567, 4'd0, 12'hFFF, 0);
    do_req(lanes, 4'd3, 12'hAAA, 0);
    do_req(lanes, 4'd7, 12'h555, 0);
    do_req(lanes, 4'd8, 12'h3C3, 5);
    do_req(lanes, 4'd13, 12'h3C3, 1);
    do_req(lanes, 4'd5, 12'h0F0, 0);
    do_req(lanes, 4'd6, 12'h00F, 2);

    // Reset during the first SHIFT cycle drops the request.
    in_valid = 1'b1; in_data = lanes; in_amt = 4'd7; in_fill = 12'h555;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", {95'd0, out_valid}, 96'd0);
    check_eq("midrst_in_ready", {95'd0, in_ready}, 96'd1);
    check_eq("midrst_out_data", out_data, 96'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("post_rst_no_valid", {95'd0, out_valid}, 96'd0);
    end
    do_req(lanes, 4'd2, 12'h777, 0);

    for (int i = 0; i < 10; i++) begin
      do_req({$urandom, $urandom, $urandom}, 4'($urandom_range(0, 15)), 12'($urandom), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
